// File: rtl/register_file_if.sv
// Register-file bus: write-back port, two ID read ports and the issue scoreboard port.
interface register_file_if;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [15:0] wr_count;

  modport master (
    output rf_we, rf_waddr, rf_wdata, rs1_addr, rs2_addr, issue_valid, issue_rd,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, wr_count
  );

  modport slave (
    input  rf_we, rf_waddr, rf_wdata, rs1_addr, rs2_addr, issue_valid, issue_rd,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, wr_count
  );
endinterface

// File: rtl/register_file.sv
// 32x32 register file with write-through bypass, busy scoreboard and committed-write counter.
module register_file (
  input  logic           clk,
  input  logic           rst_,
  register_file_if.slave rf
);

  logic [31:0] mem_q [32];
  logic [31:0] busy_q, busy_d;
  logic [15:0] wr_count_q;
  logic        wr_en;
  logic        byp1, byp2;
  logic [31:0] rs1_data, rs2_data;
  logic        rs1_busy, rs2_busy;

  assign wr_en = rf.rf_we && (rf.rf_waddr != 5'd0);
  assign byp1  = wr_en && (rf.rf_waddr == rf.rs1_addr);
  assign byp2  = wr_en && (rf.rf_waddr == rf.rs2_addr);

  // Entry 0 is never written because wr_en excludes index 0.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int i = 0; i < 32; i++) begin
        mem_q[i] <= '0;
      end
      wr_count_q <= '0;
    end else if (wr_en) begin
      mem_q[rf.rf_waddr] <= rf.rf_wdata;
      wr_count_q         <= wr_count_q + 16'd1;
    end
  end

  // Set is applied after clear so a new producer on the same index wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[rf.rf_waddr] = 1'b0;
    end
    if (rf.issue_valid && (rf.issue_rd != 5'd0)) begin
      busy_d[rf.issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    if (rf.rs1_addr != 5'd0) begin
      rs1_data = byp1 ? rf.rf_wdata : mem_q[rf.rs1_addr];
      rs1_busy = busy_q[rf.rs1_addr] && !byp1;
    end
    if (rf.rs2_addr != 5'd0) begin
      rs2_data = byp2 ? rf.rf_wdata : mem_q[rf.rs2_addr];
      rs2_busy = busy_q[rf.rs2_addr] && !byp2;
    end
  end

  assign rf.rs1_data = rs1_data;
  assign rf.rs2_data = rs2_data;
  assign rf.rs1_busy = rs1_busy;
  assign rf.rs2_busy = rs2_busy;
  assign rf.wr_count = wr_count_q;

endmodule
